// File: rtl/axi_slave_xfer_tracker.sv
// Per-slave AXI transaction tracker: forwards master requests to the arbiter and turns the granted
// master's slave-side handshakes into single-cycle end strobes, with burst-length and watchdog checks.
module axi_slave_xfer_tracker #(
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             m0_ar_sel,
    input  logic             m1_ar_sel,
    input  logic             m1_aw_sel,
    input  logic             m2_ar_sel,
    input  logic             m2_aw_sel,
    input  logic             grant_m0,
    input  logic             grant_m1,
    input  logic             grant_m2,
    input  logic             grant_RW_m1,
    input  logic             grant_RW_m2,
    input  logic             s_arvalid,
    input  logic             s_arready,
    input  logic [LEN_W-1:0] s_arlen,
    input  logic             s_rvalid,
    input  logic             s_rready,
    input  logic             s_rlast,
    input  logic             s_awvalid,
    input  logic             s_awready,
    input  logic [LEN_W-1:0] s_awlen,
    input  logic             s_wvalid,
    input  logic             s_wready,
    input  logic             s_wlast,
    input  logic             s_bvalid,
    input  logic             s_bready,
    input  logic             err_clr,
    output logic             req_m0,
    output logic             req_m1,
    output logic             req_m2,
    output logic             req_RW_m1,
    output logic             req_RW_m2,
    output logic             end_m0,
    output logic             end_m1_R,
    output logic             end_m1_W,
    output logic             end_m2_R,
    output logic             end_m2_W,
    output logic             len_err,
    output logic             timeout_err
);

    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, RDATA, WDATA, WRESP} state_t;
    typedef enum logic [1:0] {OWN_M0, OWN_M1, OWN_M2} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              len_err_q, len_err_d;
    logic              timeout_err_q, timeout_err_d;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, hs_any;
    logic wd_fire, end_rd, end_wr, len_set, to_set;

    assign req_m0    = m0_ar_sel;
    assign req_m1    = m1_ar_sel | m1_aw_sel;
    assign req_RW_m1 = m1_ar_sel;
    assign req_m2    = m2_ar_sel | m2_aw_sel;
    assign req_RW_m2 = m2_ar_sel;

    assign ar_hs  = s_arvalid & s_arready;
    assign r_hs   = s_rvalid & s_rready;
    assign aw_hs  = s_awvalid & s_awready;
    assign w_hs   = s_wvalid & s_wready;
    assign b_hs   = s_bvalid & s_bready;
    assign hs_any = r_hs | w_hs | b_hs;

    // Fires on the TIMEOUT_CYC-th consecutive cycle without data/response progress.
    assign wd_fire = (TIMEOUT_CYC != 0) && (state_q != IDLE) && !hs_any && (wd_q == WD_LAST);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        end_rd  = 1'b0;
        end_wr  = 1'b0;
        len_set = 1'b0;
        to_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ar_hs && grant_m0) begin
                    owner_d = OWN_M0; cnt_d = s_arlen; state_d = RDATA;
                end else if (ar_hs && grant_m1 && grant_RW_m1) begin
                    owner_d = OWN_M1; cnt_d = s_arlen; state_d = RDATA;
                end else if (ar_hs && grant_m2 && grant_RW_m2) begin
                    owner_d = OWN_M2; cnt_d = s_arlen; state_d = RDATA;
                end else if (aw_hs && grant_m1 && !grant_RW_m1) begin
                    owner_d = OWN_M1; cnt_d = s_awlen; state_d = WDATA;
                end else if (aw_hs && grant_m2 && !grant_RW_m2) begin
                    owner_d = OWN_M2; cnt_d = s_awlen; state_d = WDATA;
                end
            end
            RDATA: begin
                if (aw_hs || w_hs) len_set = 1'b1;
                if (r_hs) begin
                    if (s_rlast != (cnt_q == '0)) len_set = 1'b1;
                    if (cnt_q == '0) begin
                        end_rd  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else if (wd_fire) begin
                    end_rd = 1'b1; to_set = 1'b1; state_d = IDLE;
                end
            end
            WDATA: begin
                if (ar_hs) len_set = 1'b1;
                if (w_hs) begin
                    if (s_wlast != (cnt_q == '0)) len_set = 1'b1;
                    if (cnt_q == '0) state_d = WRESP;
                    else             cnt_d = cnt_q - 1'b1;
                end else if (wd_fire) begin
                    end_wr = 1'b1; to_set = 1'b1; state_d = IDLE;
                end
            end
            WRESP: begin
                if (ar_hs) len_set = 1'b1;
                if (b_hs) begin
                    end_wr = 1'b1; state_d = IDLE;
                end else if (wd_fire) begin
                    end_wr = 1'b1; to_set = 1'b1; state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) wd_d = hs_any ? '0 : wd_q + WD_W'(1);
        if (state_d != state_q) wd_d = '0;

        len_err_d     = len_set | (len_err_q & ~err_clr);
        timeout_err_d = to_set  | (timeout_err_q & ~err_clr);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q       <= IDLE;
            owner_q       <= OWN_M0;
            cnt_q         <= '0;
            wd_q          <= '0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            wd_q          <= wd_d;
            len_err_q     <= len_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // M0 only ever owns reads, so it has no write strobe.
    assign end_m0      = end_rd & (owner_q == OWN_M0);
    assign end_m1_R    = end_rd & (owner_q == OWN_M1);
    assign end_m2_R    = end_rd & (owner_q == OWN_M2);
    assign end_m1_W    = end_wr & (owner_q == OWN_M1);
    assign end_m2_W    = end_wr & (owner_q == OWN_M2);
    assign len_err     = len_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_axi_slave_xfer_tracker.sv
// Randomized bench for axi_slave_xfer_tracker against a transaction-level reference model,
// preceded by directed read/write/error/timeout/reset scenarios.
module tb_axi_slave_xfer_tracker;

    localparam int LW = 4;
    localparam int TO = 8;

    logic ACLK = 1'b0;
    logic ARESETn;
    logic m0_ar_sel, m1_ar_sel, m1_aw_sel, m2_ar_sel, m2_aw_sel;
    logic grant_m0, grant_m1, grant_m2, grant_RW_m1, grant_RW_m2;
    logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [LW-1:0] s_arlen, s_awlen;
    logic err_clr;
    logic req_m0, req_m1, req_m2, req_RW_m1, req_RW_m2;
    logic end_m0, end_m1_R, end_m1_W, end_m2_R, end_m2_W, len_err, timeout_err;

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0=none, 1=reading, 2=writing data, 3=awaiting response.
    int mPhase, mRem, mOwner, mIdle;
    bit mLenErr, mToErr;
    logic [4:0] lastEnd;

    axi_slave_xfer_tracker #(.LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m0_ar_sel(m0_ar_sel), .m1_ar_sel(m1_ar_sel), .m1_aw_sel(m1_aw_sel),
        .m2_ar_sel(m2_ar_sel), .m2_aw_sel(m2_aw_sel),
        .grant_m0(grant_m0), .grant_m1(grant_m1), .grant_m2(grant_m2),
        .grant_RW_m1(grant_RW_m1), .grant_RW_m2(grant_RW_m2),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awlen(s_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .err_clr(err_clr),
        .req_m0(req_m0), .req_m1(req_m1), .req_m2(req_m2),
        .req_RW_m1(req_RW_m1), .req_RW_m2(req_RW_m2),
        .end_m0(end_m0), .end_m1_R(end_m1_R), .end_m1_W(end_m1_W),
        .end_m2_R(end_m2_R), .end_m2_W(end_m2_W),
        .len_err(len_err), .timeout_err(timeout_err)
    );

    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic clearInputs();
        {m0_ar_sel, m1_ar_sel, m1_aw_sel, m2_ar_sel, m2_aw_sel} = '0;
        {grant_m0, grant_m1, grant_m2, grant_RW_m1, grant_RW_m2} = '0;
        {s_arvalid, s_arready, s_rvalid, s_rready, s_rlast} = '0;
        {s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready} = '0;
        s_arlen = '0; s_awlen = '0; err_clr = 1'b0;
    endtask

    function automatic bit chance(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    // Random inputs for one cycle; rate scales slave data/response throughput (0 = stalled slave).
    task automatic applyStimulus(input int rate);
        {m0_ar_sel, m1_ar_sel, m1_aw_sel, m2_ar_sel, m2_aw_sel} = 5'($urandom);
        grant_m0 = chance(25); grant_m1 = chance(40); grant_m2 = chance(40);
        grant_RW_m1 = chance(50); grant_RW_m2 = chance(50);
        s_arvalid = chance(20); s_arready = chance(70); s_arlen = LW'($urandom_range(3));
        s_awvalid = chance(20); s_awready = chance(70); s_awlen = LW'($urandom_range(3));
        s_rvalid = chance(rate * 10); s_rready = chance(85);
        s_wvalid = chance(rate * 10); s_wready = chance(85);
        s_bvalid = chance(rate * 10); s_bready = chance(85);
        s_rlast = (mPhase == 1 && chance(90)) ? (mRem == 0) : chance(50);
        s_wlast = (mPhase == 2 && chance(90)) ? (mRem == 0) : chance(50);
        err_clr = chance(8);
    endtask

    // Compare this cycle's outputs against the model, advance the model, then move to the next negedge.
    task automatic stepCycle();
        bit arHs, rHs, awHs, wHs, bHs, hsAny, toFire, endR, endW, setLen;
        bit wr1, wr2, rd1, rd2;
        int nPhase;
        logic [4:0] expEnd;
        #2;
        if (!ARESETn) begin
            mPhase = 0; mRem = 0; mOwner = 0; mIdle = 0; mLenErr = 0; mToErr = 0;
        end
        arHs = s_arvalid & s_arready; rHs = s_rvalid & s_rready; awHs = s_awvalid & s_awready;
        wHs = s_wvalid & s_wready; bHs = s_bvalid & s_bready; hsAny = rHs | wHs | bHs;
        toFire = ARESETn && (mPhase != 0) && !hsAny && (mIdle == TO - 1);
        endR = ARESETn && (mPhase == 1) && ((rHs && mRem == 0) || toFire);
        endW = ARESETn && (((mPhase == 2) && toFire) || ((mPhase == 3) && (bHs || toFire)));
        expEnd = {endR && mOwner == 0, endR && mOwner == 1, endW && mOwner == 1,
                  endR && mOwner == 2, endW && mOwner == 2};
        lastEnd = {end_m0, end_m1_R, end_m1_W, end_m2_R, end_m2_W};
        checkOutput("req", {7'b0, req_m0, req_m1, req_m2, req_RW_m1, req_RW_m2},
                    {7'b0, m0_ar_sel, m1_ar_sel | m1_aw_sel, m2_ar_sel | m2_aw_sel, m1_ar_sel, m2_ar_sel});
        checkOutput("end", {7'b0, lastEnd}, {7'b0, expEnd});
        checkOutput("err", {10'b0, len_err, timeout_err}, {10'b0, mLenErr, mToErr});
        if (ARESETn) begin
            setLen = ((mPhase == 1) && ((rHs && (s_rlast != (mRem == 0))) || awHs || wHs)) ||
                     ((mPhase == 2) && wHs && (s_wlast != (mRem == 0))) ||
                     ((mPhase == 2 || mPhase == 3) && arHs);
            mLenErr = setLen | (mLenErr & !err_clr);
            mToErr  = toFire | (mToErr & !err_clr);
            rd1 = grant_m1 & grant_RW_m1; rd2 = grant_m2 & grant_RW_m2;
            wr1 = grant_m1 & !grant_RW_m1; wr2 = grant_m2 & !grant_RW_m2;
            nPhase = mPhase;
            case (mPhase)
                0: if (arHs && (grant_m0 || rd1 || rd2)) begin
                       nPhase = 1; mRem = s_arlen; mOwner = grant_m0 ? 0 : (rd1 ? 1 : 2);
                   end else if (awHs && (wr1 || wr2)) begin
                       nPhase = 2; mRem = s_awlen; mOwner = wr1 ? 1 : 2;
                   end
                1: if (rHs) begin
                       if (mRem == 0) nPhase = 0; else mRem--;
                   end else if (toFire) nPhase = 0;
                2: if (wHs) begin
                       if (mRem == 0) nPhase = 3; else mRem--;
                   end else if (toFire) nPhase = 0;
                default: if (bHs || toFire) nPhase = 0;
            endcase
            if (nPhase != mPhase) mIdle = 0;
            else if (mPhase != 0) mIdle = hsAny ? 0 : mIdle + 1;
            mPhase = nPhase;
        end
        @(negedge ACLK);
    endtask

    task automatic readBeat(input bit last);
        clearInputs();
        s_rvalid = 1'b1; s_rready = 1'b1; s_rlast = last;
        stepCycle();
    endtask

    initial begin
        int latency;
        ARESETn = 1'b0;
        clearInputs();
        mPhase = 0; mRem = 0; mOwner = 0; mIdle = 0; mLenErr = 0; mToErr = 0;
        @(negedge ACLK);
        stepCycle();
        checkOutput("reset_outputs", {5'b0, end_m0, end_m1_R, end_m1_W, end_m2_R, end_m2_W, len_err, timeout_err}, 12'h000);
        ARESETn = 1'b1;
        stepCycle();

        $display("[TB] M0 read, 4 beats");
        clearInputs(); grant_m0 = 1; s_arvalid = 1; s_arready = 1; s_arlen = 4'd3; m0_ar_sel = 1;
        stepCycle();
        for (int i = 0; i < 4; i++) readBeat(i == 3);
        checkOutput("m0_end_beat4", {7'b0, lastEnd}, 12'h010);

        $display("[TB] M1 write with delayed response");
        clearInputs(); grant_m1 = 1; s_awvalid = 1; s_awready = 1; s_awlen = 4'd1; m1_aw_sel = 1;
        stepCycle();
        for (int i = 0; i < 2; i++) begin
            clearInputs(); s_wvalid = 1; s_wready = 1; s_wlast = (i == 1);
            stepCycle();
        end
        for (int i = 0; i < 3; i++) begin clearInputs(); stepCycle(); end
        clearInputs(); s_bvalid = 1; s_bready = 1;
        stepCycle();
        checkOutput("m1_end_write", {7'b0, lastEnd}, 12'h004);

        $display("[TB] M2 read with early RLAST");
        clearInputs(); grant_m2 = 1; grant_RW_m2 = 1; s_arvalid = 1; s_arready = 1; s_arlen = 4'd2;
        stepCycle();
        readBeat(0); readBeat(1); readBeat(1);
        checkOutput("m2_end_read", {7'b0, lastEnd}, 12'h002);
        clearInputs(); stepCycle();
        checkOutput("len_err_set", {11'b0, len_err}, 12'h001);
        clearInputs(); err_clr = 1; stepCycle();
        clearInputs(); stepCycle();
        checkOutput("len_err_clr", {11'b0, len_err}, 12'h000);

        $display("[TB] M1 read timeout");
        clearInputs(); grant_m1 = 1; grant_RW_m1 = 1; s_arvalid = 1; s_arready = 1; s_arlen = 4'd2;
        stepCycle();
        latency = -1;
        for (int k = 1; k <= 3 * TO && latency < 0; k++) begin
            clearInputs(); stepCycle();
            if (lastEnd == 5'b01000) latency = k;
        end
        checkOutput("timeout_latency", 12'(latency), 12'(TO));
        clearInputs(); stepCycle();
        checkOutput("timeout_err_set", {11'b0, timeout_err}, 12'h001);

        $display("[TB] ungranted AR is ignored");
        clearInputs(); m1_ar_sel = 1; m1_aw_sel = 1; s_arvalid = 1; s_arready = 1; s_arlen = 4'd0;
        stepCycle();
        readBeat(1);
        checkOutput("no_grant_no_end", {7'b0, lastEnd}, 12'h000);

        $display("[TB] reset mid-burst");
        clearInputs(); grant_m0 = 1; s_arvalid = 1; s_arready = 1; s_arlen = 4'd3;
        stepCycle();
        readBeat(0);
        clearInputs(); s_rvalid = 1; s_rready = 1; ARESETn = 1'b0;
        stepCycle();
        ARESETn = 1'b1;
        clearInputs(); grant_m0 = 1; s_arvalid = 1; s_arready = 1; s_arlen = 4'd1;
        stepCycle();
        readBeat(0); readBeat(1);
        checkOutput("post_reset_end", {7'b0, lastEnd}, 12'h010);

        $display("[TB] randomized traffic");
        begin
            int rate;
            rate = 5;
            for (int c = 0; c < 3000; c++) begin
                if (c % 64 == 0) rate = $urandom_range(10);
                applyStimulus(rate);
                stepCycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
